// File: rtl/alu_dest_demux_pkg.sv
// Shared widths and buffer state encoding for the ALU destination demux.
package alu_dest_demux_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned DEST_N  = 4;
    localparam int unsigned DEST_W  = 2;
    localparam int unsigned COUNT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

endpackage : alu_dest_demux_pkg

// File: rtl/dest_onehot_decoder.sv
// 2-to-4 one-hot decode of a destination index.
module dest_onehot_decoder
    import alu_dest_demux_pkg::*;
(
    input  logic [DEST_W-1:0] sel,
    output logic [DEST_N-1:0] onehot
);

    // Exactly one bit set for every index; all codes are legal.
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule : dest_onehot_decoder

// File: rtl/alu_dest_demux.sv
// One-entry buffer steering an ALU result to one of four destinations.
module alu_dest_demux
    import alu_dest_demux_pkg::*;
(
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WORD_W-1:0]  Result,
    input  logic [DEST_W-1:0]  ALUDest,
    input  logic               Flush,
    output logic [DEST_N-1:0]  OutValid,
    output logic [WORD_W-1:0]  OutData,
    input  logic [DEST_N-1:0]  OutReady,
    output logic               Busy,
    output logic [COUNT_W-1:0] DeliveredCount
);

    buf_state_t        state;
    logic [DEST_W-1:0] dest;
    logic [DEST_N-1:0] dest_onehot_c;
    logic              sel_ready_c;
    logic              out_xfer_c;
    logic              in_xfer_c;

    // Decode the incoming destination so OutValid can be loaded as a flop.
    dest_onehot_decoder u_dec (
        .sel    (ALUDest),
        .onehot (dest_onehot_c)
    );

    // Only the held destination's ready matters; Flush blocks both transfers.
    assign sel_ready_c = OutReady[dest];
    assign out_xfer_c  = (state == FULL) && sel_ready_c && !Flush;
    assign InReady     = !Flush && ((state == EMPTY) || sel_ready_c);
    assign in_xfer_c   = InValid && InReady;

    // Buffer state, held word/destination, registered outputs and delivery count.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= EMPTY;
            dest           <= '0;
            OutData        <= '0;
            OutValid       <= '0;
            Busy           <= 1'b0;
            DeliveredCount <= '0;
        end else begin
            if (Flush) begin
                state    <= EMPTY;
                OutValid <= '0;
                Busy     <= 1'b0;
            end else if (in_xfer_c) begin
                // Covers both EMPTY load and same-edge refill while FULL.
                state    <= FULL;
                dest     <= ALUDest;
                OutData  <= Result;
                OutValid <= dest_onehot_c;
                Busy     <= 1'b1;
            end else if (out_xfer_c) begin
                state    <= EMPTY;
                OutValid <= '0;
                Busy     <= 1'b0;
            end

            if (out_xfer_c) begin
                DeliveredCount <= DeliveredCount + COUNT_W'(1);
            end
        end
    end

endmodule : alu_dest_demux

// File: tb/tb_alu_dest_demux.sv
// Self-checking bench for alu_dest_demux with a scoreboard of accepted words.
module tb_alu_dest_demux;

    logic        CLK;
    logic        Reset_n;
    logic        InValid;
    logic        InReady;
    logic [15:0] Result;
    logic [1:0]  ALUDest;
    logic        Flush;
    logic [3:0]  OutValid;
    logic [15:0] OutData;
    logic [3:0]  OutReady;
    logic        Busy;
    logic [7:0]  DeliveredCount;

    typedef struct packed {
        logic [1:0]  dest;
        logic [15:0] data;
    } item_t;

    item_t       sb[$];
    int          checks;
    int          errors;
    logic        m_full;
    logic [1:0]  m_dest;
    logic [7:0]  m_count;

    alu_dest_demux dut (
        .CLK            (CLK),
        .Reset_n        (Reset_n),
        .InValid        (InValid),
        .InReady        (InReady),
        .Result         (Result),
        .ALUDest        (ALUDest),
        .Flush          (Flush),
        .OutValid       (OutValid),
        .OutData        (OutData),
        .OutReady       (OutReady),
        .Busy           (Busy),
        .DeliveredCount (DeliveredCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        sb.delete();
        m_full  = 1'b0;
        m_dest  = 2'd0;
        m_count = 8'd0;
    endtask

    // Sample 2ns after a negedge, score this cycle's transfers, advance to next negedge.
    task automatic tick();
        logic  exp_ready;
        logic  out_x;
        logic  in_x;
        logic [3:0] exp_v;
        item_t it;
        #2;
        exp_ready = !Flush && (!m_full || OutReady[m_dest]);
        out_x     = m_full && OutReady[m_dest] && !Flush;
        in_x      = InValid && exp_ready;
        checks++;
        if (InReady !== exp_ready) begin
            errors++;
            $display("FAIL inready: got %b want %b", InReady, exp_ready);
        end
        checks++;
        if (DeliveredCount !== m_count) begin
            errors++;
            $display("FAIL count: got %0d want %0d", DeliveredCount, m_count);
        end
        if (out_x) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: got transfer want none queued");
            end else begin
                it    = sb.pop_front();
                exp_v = 4'b0001 << it.dest;
                checks++;
                if (OutData !== it.data || OutValid !== exp_v) begin
                    errors++;
                    $display("FAIL deliver: got %h/%b want %h/%b", OutData, OutValid, it.data, exp_v);
                end
            end
            m_count = m_count + 8'd1;
        end
        if (Flush) begin
            sb.delete();
            m_full = 1'b0;
        end else if (in_x) begin
            sb.push_back('{dest: ALUDest, data: Result});
            m_full = 1'b1;
            m_dest = ALUDest;
        end else if (out_x) begin
            m_full = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        InValid  = 1'b0;
        Result   = 16'h0000;
        ALUDest  = 2'd0;
        Flush    = 1'b0;
        OutReady = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    task automatic load(input logic [1:0] d, input logic [15:0] v);
        InValid = 1'b1;
        ALUDest = d;
        Result  = v;
        tick();
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        checks++;
        if (OutValid !== 4'b0000 || OutData !== 16'h0000 || Busy !== 1'b0 ||
            DeliveredCount !== 8'd0 || InReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h b=%b c=%0d r=%b want 0000/0000/0/0/1",
                     OutValid, OutData, Busy, DeliveredCount, InReady);
        end
        @(negedge CLK);
    endtask

    task automatic test_single();
        load(2'd2, 16'h00A5);
        #2;
        checks++;
        if (OutValid !== 4'b0100 || OutData !== 16'h00A5 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL single_out: got %b/%h/%b want 0100/00a5/1", OutValid, OutData, Busy);
        end
        @(negedge CLK);
        tick();
        OutReady = 4'b0100;
        tick();
        OutReady = 4'b0000;
        #2;
        checks++;
        if (Busy !== 1'b0 || OutValid !== 4'b0000) begin
            errors++;
            $display("FAIL single_drain: got %b/%b want 0/0000", Busy, OutValid);
        end
        @(negedge CLK);
    endtask

    task automatic test_backpressure();
        logic [7:0] c0;
        load(2'd1, 16'h1234);
        c0 = m_count;
        InValid = 1'b1;
        Result  = 16'hFFFF;
        ALUDest = 2'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (OutData !== 16'h1234 || InReady !== 1'b0 || DeliveredCount !== c0 ||
                OutValid !== 4'b0010) begin
                errors++;
                $display("FAIL hold: got %h/%b/%0d/%b want 1234/0/%0d/0010",
                         OutData, InReady, DeliveredCount, OutValid, c0);
            end
            #1;
            tick();
        end
        InValid  = 1'b0;
        OutReady = 4'b0010;
        tick();
        OutReady = 4'b0000;
        #2;
        checks++;
        if (DeliveredCount !== c0 + 8'd1) begin
            errors++;
            $display("FAIL bp_release: got %0d want %0d", DeliveredCount, c0 + 8'd1);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        logic [3:0] walk;
        do_reset();
        OutReady = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            InValid = (i < 4);
            ALUDest = 2'(i);
            Result  = 16'(i);
            if (i > 0) begin
                walk = 4'b0001 << (i - 1);
                #1;
                checks++;
                if (OutValid !== walk || OutData !== 16'(i - 1)) begin
                    errors++;
                    $display("FAIL stream_walk%0d: got %b/%h want %b/%h", i, OutValid, OutData, walk, 16'(i - 1));
                end
                #1;
            end
            tick();
        end
        InValid = 1'b0;
        #2;
        checks++;
        if (DeliveredCount !== 8'd4 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_count: got %0d/%b want 4/0", DeliveredCount, Busy);
        end
        @(negedge CLK);
        OutReady = 4'b0000;
    endtask

    task automatic test_wrong_dest();
        logic [7:0] c0;
        load(2'd3, 16'hBEEF);
        c0 = m_count;
        OutReady = 4'b0111;
        InValid  = 1'b1;
        Result   = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (InReady !== 1'b0 || OutValid !== 4'b1000 || DeliveredCount !== c0) begin
                errors++;
                $display("FAIL wrong_dest: got %b/%b/%0d want 0/1000/%0d", InReady, OutValid, DeliveredCount, c0);
            end
            #1;
            tick();
        end
        InValid  = 1'b0;
        OutReady = 4'b1000;
        tick();
        OutReady = 4'b0000;
        #2;
        checks++;
        if (DeliveredCount !== c0 + 8'd1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL wrong_release: got %0d/%b want %0d/0", DeliveredCount, Busy, c0 + 8'd1);
        end
        @(negedge CLK);
    endtask

    task automatic test_flush();
        logic [7:0] c0;
        load(2'd0, 16'hCAFE);
        c0 = m_count;
        OutReady = 4'b0001;
        Flush    = 1'b1;
        InValid  = 1'b1;
        ALUDest  = 2'd1;
        Result   = 16'h7777;
        tick();
        Flush    = 1'b0;
        InValid  = 1'b0;
        OutReady = 4'b0000;
        #2;
        checks++;
        if (Busy !== 1'b0 || OutValid !== 4'b0000 || DeliveredCount !== c0) begin
            errors++;
            $display("FAIL flush: got %b/%b/%0d want 0/0000/%0d", Busy, OutValid, DeliveredCount, c0);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        load(2'd2, 16'h4321);
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (OutValid !== 4'b0000 || DeliveredCount !== 8'd0 || Busy !== 1'b0 || OutData !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got %b/%0d/%b/%h want 0000/0/0/0000", OutValid, DeliveredCount, Busy, OutData);
        end
        model_reset();
        @(negedge CLK);
        Reset_n = 1'b1;
        #2;
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 1", InReady);
        end
        @(negedge CLK);
    endtask

    task automatic test_wrap();
        do_reset();
        OutReady = 4'b1111;
        InValid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ALUDest = 2'($urandom_range(0, 3));
            Result  = 16'($urandom);
            tick();
        end
        InValid = 1'b0;
        #1;
        checks++;
        if (DeliveredCount !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: got %0d want 255", DeliveredCount);
        end
        #1;
        tick();
        OutReady = 4'b0000;
        #2;
        checks++;
        if (DeliveredCount !== 8'd0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_0: got %0d/%b want 0/0", DeliveredCount, Busy);
        end
        @(negedge CLK);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        Reset_n = 1'b1;
        model_reset();
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_wrong_dest();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_dest_demux
